// File: rtl/crtc_pkg.sv
// Shared CRTC definitions: register indices, reset defaults, timing register bundle.
package crtc_pkg;

  localparam int unsigned REG_W = 8;
  localparam int unsigned SEL_W = 5;

  localparam logic [SEL_W-1:0] CRTC_R0_H_TOTAL      = 5'd0;
  localparam logic [SEL_W-1:0] CRTC_R1_H_DISP       = 5'd1;
  localparam logic [SEL_W-1:0] CRTC_R2_H_SYNC_POS   = 5'd2;
  localparam logic [SEL_W-1:0] CRTC_R3_SYNC_WIDTH   = 5'd3;
  localparam logic [SEL_W-1:0] CRTC_R4_V_TOTAL      = 5'd4;
  localparam logic [SEL_W-1:0] CRTC_R5_V_ADJUST     = 5'd5;
  localparam logic [SEL_W-1:0] CRTC_R6_V_DISP       = 5'd6;
  localparam logic [SEL_W-1:0] CRTC_R7_V_SYNC_POS   = 5'd7;
  localparam logic [SEL_W-1:0] CRTC_R9_MAX_SCAN     = 5'd9;
  localparam logic [SEL_W-1:0] CRTC_R10_CURSOR_START = 5'd10;
  localparam logic [SEL_W-1:0] CRTC_R11_CURSOR_END  = 5'd11;
  localparam logic [SEL_W-1:0] CRTC_R12_START_HI    = 5'd12;
  localparam logic [SEL_W-1:0] CRTC_R13_START_LO    = 5'd13;
  localparam logic [SEL_W-1:0] CRTC_R14_CURSOR_HI   = 5'd14;
  localparam logic [SEL_W-1:0] CRTC_R15_CURSOR_LO   = 5'd15;

  localparam logic [REG_W-1:0] CRTC_DEF_R0  = 8'd63;
  localparam logic [REG_W-1:0] CRTC_DEF_R1  = 8'd40;
  localparam logic [REG_W-1:0] CRTC_DEF_R2  = 8'd50;
  localparam logic [REG_W-1:0] CRTC_DEF_R3  = 8'h48;
  localparam logic [REG_W-1:0] CRTC_DEF_R4  = 8'd32;
  localparam logic [REG_W-1:0] CRTC_DEF_R5  = 8'd4;
  localparam logic [REG_W-1:0] CRTC_DEF_R6  = 8'd25;
  localparam logic [REG_W-1:0] CRTC_DEF_R7  = 8'd28;
  localparam logic [REG_W-1:0] CRTC_DEF_R9  = 8'd7;
  localparam logic [REG_W-1:0] CRTC_DEF_R12 = 8'h10;
  localparam logic [REG_W-1:0] CRTC_DEF_R13 = 8'h00;

  typedef struct packed {
    logic [REG_W-1:0] r0;
    logic [REG_W-1:0] r1;
    logic [REG_W-1:0] r2;
    logic [REG_W-1:0] r3;
    logic [REG_W-1:0] r4;
    logic [REG_W-1:0] r5;
    logic [REG_W-1:0] r6;
    logic [REG_W-1:0] r7;
    logic [REG_W-1:0] r9;
    logic [REG_W-1:0] r10;
    logic [REG_W-1:0] r11;
    logic [REG_W-1:0] r12;
    logic [REG_W-1:0] r13;
    logic [REG_W-1:0] r14;
    logic [REG_W-1:0] r15;
  } crtc_regs_t;

  localparam crtc_regs_t CRTC_REGS_RESET = '{
    r0: CRTC_DEF_R0, r1: CRTC_DEF_R1, r2: CRTC_DEF_R2, r3: CRTC_DEF_R3,
    r4: CRTC_DEF_R4, r5: CRTC_DEF_R5, r6: CRTC_DEF_R6, r7: CRTC_DEF_R7,
    r9: CRTC_DEF_R9, r10: 8'h00, r11: 8'h00, r12: CRTC_DEF_R12,
    r13: CRTC_DEF_R13, r14: 8'h00, r15: 8'h00
  };

  // Sync width field decode: a zero field means the maximum of 16.
  function automatic logic [4:0] sync_width(input logic [3:0] w);
    return (w == 4'd0) ? 5'd16 : {1'b0, w};
  endfunction

endpackage

// File: rtl/crtc_responder_if.sv
// CPU bus view of the CRTC: decoded chip select, commit strobe, register pair access.
interface crtc_responder_if;
  import crtc_pkg::*;

  logic             crtc_en_i;
  logic             cpu_strobe_i;
  logic             cpu_we_i;
  logic             addr_i;
  logic [REG_W-1:0] data_i;
  logic [REG_W-1:0] data_o;

  modport master (output crtc_en_i, cpu_strobe_i, cpu_we_i, addr_i, data_i, input data_o);
  modport slave  (input crtc_en_i, cpu_strobe_i, cpu_we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/crtc_responder_timing.sv
// Character-clock video timing: h/v counters, adjust phase, syncs, DE, MA/RA, cursor.
// Cursor output is generated only when CRTC_CURSOR_EN is defined.
module crtc_timing
  import crtc_pkg::*;
#(
  parameter int unsigned MA_WIDTH = 14,
  parameter int unsigned RA_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                char_clk_en_i,
  input  crtc_regs_t          regs,
  output logic                h_sync_o,
  output logic                v_sync_o,
  output logic                de_o,
  output logic [MA_WIDTH-1:0] ma_o,
  output logic [RA_WIDTH-1:0] ra_o,
  output logic                cursor_o
);

  logic                start_pend, start_pend_n;
  logic [7:0]          h_cnt, h_cnt_n;
  logic [7:0]          row, row_n;
  logic [7:0]          adj_cnt, adj_cnt_n;
  logic [RA_WIDTH-1:0] ra, ra_n;
  logic                adjust, adjust_n;
  logic [MA_WIDTH-1:0] ma_row, ma_row_n;
  logic [4:0]          hs_rem, hs_rem_n;
  logic [4:0]          vs_rem, vs_rem_n;
  logic                frame_start, line_start;
  logic [MA_WIDTH-1:0] ma_n;
  logic                de_n, cursor_n;
  logic                unused_regs;

  assign unused_regs = ^{regs.r10, regs.r11, regs.r14, regs.r15, regs.r12[7:6]};

  // Next counter state and next output values for the coming character tick.
  always_comb begin
    start_pend_n = start_pend;
    h_cnt_n      = h_cnt;
    row_n        = row;
    adj_cnt_n    = adj_cnt;
    ra_n         = ra;
    adjust_n     = adjust;
    ma_row_n     = ma_row;
    hs_rem_n     = hs_rem;
    vs_rem_n     = vs_rem;
    frame_start  = start_pend;
    line_start   = start_pend;

    if (!start_pend) begin
      if (h_cnt >= regs.r0) begin
        line_start = 1'b1;
        h_cnt_n    = 8'd0;
        if (adjust) begin
          if (({1'b0, adj_cnt} + 9'd1) >= {1'b0, regs.r5}) frame_start = 1'b1;
          else adj_cnt_n = adj_cnt + 8'd1;
        end else if (8'(ra) >= regs.r9) begin
          ra_n     = '0;
          ma_row_n = ma_row + MA_WIDTH'(regs.r1);
          if (row >= regs.r4) begin
            if (regs.r5 == 8'd0) begin
              frame_start = 1'b1;
            end else begin
              adjust_n  = 1'b1;
              adj_cnt_n = 8'd0;
            end
          end else begin
            row_n = row + 8'd1;
          end
        end else begin
          ra_n = ra + RA_WIDTH'(1);
        end
      end else begin
        h_cnt_n = h_cnt + 8'd1;
      end
    end

    if (frame_start) begin
      start_pend_n = 1'b0;
      h_cnt_n      = 8'd0;
      row_n        = 8'd0;
      ra_n         = '0;
      adjust_n     = 1'b0;
      adj_cnt_n    = 8'd0;
      ma_row_n     = MA_WIDTH'({regs.r12[5:0], regs.r13});
    end

    if (h_cnt_n == regs.r2) hs_rem_n = sync_width(regs.r3[3:0]);
    else if (hs_rem != 5'd0) hs_rem_n = hs_rem - 5'd1;

    if (line_start) begin
      if (!adjust_n && (row_n == regs.r7) && (ra_n == '0)) vs_rem_n = sync_width(regs.r3[7:4]);
      else if (vs_rem != 5'd0) vs_rem_n = vs_rem - 5'd1;
    end

    ma_n = ma_row_n + MA_WIDTH'(h_cnt_n);
    de_n = (h_cnt_n < regs.r1) && (row_n < regs.r6) && !adjust_n;
`ifdef CRTC_CURSOR_EN
    cursor_n = de_n && (ma_n == MA_WIDTH'({regs.r14[5:0], regs.r15}))
               && (8'(ra_n) >= {3'b000, regs.r10[4:0]})
               && (8'(ra_n) <= {3'b000, regs.r11[4:0]});
`else
    cursor_n = 1'b0;
`endif
  end

  // Counter state advances on each character tick; reset re-arms a frame start.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      start_pend <= 1'b1;
      h_cnt      <= 8'd0;
      row        <= 8'd0;
      adj_cnt    <= 8'd0;
      ra         <= '0;
      adjust     <= 1'b0;
      ma_row     <= '0;
      hs_rem     <= 5'd0;
      vs_rem     <= 5'd0;
    end else if (char_clk_en_i) begin
      start_pend <= start_pend_n;
      h_cnt      <= h_cnt_n;
      row        <= row_n;
      adj_cnt    <= adj_cnt_n;
      ra         <= ra_n;
      adjust     <= adjust_n;
      ma_row     <= ma_row_n;
      hs_rem     <= hs_rem_n;
      vs_rem     <= vs_rem_n;
    end
  end

  // Registered timing outputs, refreshed on the same tick as the counters.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      h_sync_o <= 1'b0;
      v_sync_o <= 1'b0;
      de_o     <= 1'b0;
      ma_o     <= '0;
      ra_o     <= '0;
      cursor_o <= 1'b0;
    end else if (char_clk_en_i) begin
      h_sync_o <= (hs_rem_n != 5'd0);
      v_sync_o <= (vs_rem_n != 5'd0);
      de_o     <= de_n;
      ma_o     <= ma_n;
      ra_o     <= ra_n;
      cursor_o <= cursor_n;
    end
  end

endmodule

// File: rtl/crtc_responder.sv
// CRTC bus responder: address/data register pair, register file, timing generator.
// Cursor registers R10/R11/R14/R15 exist only when CRTC_CURSOR_EN is defined.
module crtc_responder
  import crtc_pkg::*;
#(
  parameter int unsigned MA_WIDTH = 14,
  parameter int unsigned RA_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  crtc_responder_if.slave     bus,
  input  logic                char_clk_en_i,
  output logic                h_sync_o,
  output logic                v_sync_o,
  output logic                de_o,
  output logic [MA_WIDTH-1:0] ma_o,
  output logic [RA_WIDTH-1:0] ra_o,
  output logic                cursor_o
);

  logic [SEL_W-1:0] sel;
  crtc_regs_t       regs;
  logic             access;

  assign access = bus.crtc_en_i && bus.cpu_strobe_i;

  // Register select and data register writes; unknown indices fall through.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sel  <= '0;
      regs <= CRTC_REGS_RESET;
    end else if (access && bus.cpu_we_i) begin
      if (!bus.addr_i) begin
        sel <= bus.data_i[SEL_W-1:0];
      end else begin
        case (sel)
          CRTC_R0_H_TOTAL:       regs.r0  <= bus.data_i;
          CRTC_R1_H_DISP:        regs.r1  <= bus.data_i;
          CRTC_R2_H_SYNC_POS:    regs.r2  <= bus.data_i;
          CRTC_R3_SYNC_WIDTH:    regs.r3  <= bus.data_i;
          CRTC_R4_V_TOTAL:       regs.r4  <= bus.data_i;
          CRTC_R5_V_ADJUST:      regs.r5  <= bus.data_i;
          CRTC_R6_V_DISP:        regs.r6  <= bus.data_i;
          CRTC_R7_V_SYNC_POS:    regs.r7  <= bus.data_i;
          CRTC_R9_MAX_SCAN:      regs.r9  <= bus.data_i;
          CRTC_R12_START_HI:     regs.r12 <= bus.data_i;
          CRTC_R13_START_LO:     regs.r13 <= bus.data_i;
`ifdef CRTC_CURSOR_EN
          CRTC_R10_CURSOR_START: regs.r10 <= bus.data_i;
          CRTC_R11_CURSOR_END:   regs.r11 <= bus.data_i;
          CRTC_R14_CURSOR_HI:    regs.r14 <= bus.data_i;
          CRTC_R15_CURSOR_LO:    regs.r15 <= bus.data_i;
`endif
          default: ;
        endcase
      end
    end
  end

  // Combinational read mux: only the address registers R12-R15 read back.
  always_comb begin
    bus.data_o = 8'h00;
    if (bus.addr_i) begin
      case (sel)
        CRTC_R12_START_HI:  bus.data_o = regs.r12;
        CRTC_R13_START_LO:  bus.data_o = regs.r13;
`ifdef CRTC_CURSOR_EN
        CRTC_R14_CURSOR_HI: bus.data_o = regs.r14;
        CRTC_R15_CURSOR_LO: bus.data_o = regs.r15;
`endif
        default:            bus.data_o = 8'h00;
      endcase
    end
  end

  crtc_timing #(
    .MA_WIDTH(MA_WIDTH),
    .RA_WIDTH(RA_WIDTH)
  ) u_timing (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .char_clk_en_i(char_clk_en_i),
    .regs         (regs),
    .h_sync_o     (h_sync_o),
    .v_sync_o     (v_sync_o),
    .de_o         (de_o),
    .ma_o         (ma_o),
    .ra_o         (ra_o),
    .cursor_o     (cursor_o)
  );

endmodule
